// File: rtl/game_sequencer.sv
// game_sequencer: top-level game flow controller.
// Sequences attract / play / respawn / wave-clear / game-over states and
// tracks score, lives and wave number from the enemy kill and player hit
// pulses. frame_clk is treated as asynchronous data and is synchronised
// before its rising edges are used as frame ticks.
// Optional feature: define GAME_SEQUENCER_HISCORE_EN to add the hi_score
// output and its register.
module game_sequencer #(
    parameter int         N_ENEMY        = 18,
    parameter int         LIVES          = 3,
    parameter int         N_WAVES        = 4,
    parameter int         SCORE_W        = 8,
    parameter logic [7:0] KEY_START      = 8'h28,
    parameter int         CLEAR_FRAMES   = 120,
    parameter int         RESPAWN_FRAMES = 60
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_clk,
    input  logic [7:0]         keycode,
    input  logic [N_ENEMY-1:0] kill_pulse,
    input  logic               player_hit,
    output logic               start,
    output logic               play,
    output logic               respawn,
    output logic               wave_clear,
    output logic               gameover,
    output logic               wave_start,
    output logic               won,
    output logic [2:0]         lives,
    output logic [3:0]         wave_num,
    output logic [SCORE_W-1:0] score
`ifdef GAME_SEQUENCER_HISCORE_EN
    ,
    output logic [SCORE_W-1:0] hi_score
`endif
);

    // Popcount of up to 32 kill bits fits in 6 bits.
    localparam int PW    = 6;
    // Kill counter holds at most (N_ENEMY-1) + 32 before it is cleared.
    localparam int KW    = 7;
    // Sum wide enough to detect score overflow for any SCORE_W.
    localparam int SUM_W = ((SCORE_W > PW) ? SCORE_W : PW) + 1;
    localparam int FMAX  = (CLEAR_FRAMES > RESPAWN_FRAMES) ? CLEAR_FRAMES : RESPAWN_FRAMES;
    localparam int FW    = $clog2(FMAX + 1);

    typedef enum logic [2:0] {
        S_ATTRACT,
        S_PLAY,
        S_RESPAWN,
        S_WAVE_CLEAR,
        S_GAMEOVER
    } state_t;

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [2:0]         lives_q, lives_d;
    logic [3:0]         wave_num_q, wave_num_d;
    logic [KW-1:0]      kill_cnt_q, kill_cnt_d;
    logic [FW-1:0]      frame_cnt_q, frame_cnt_d;
    logic               won_q, won_d;
    logic               wave_start_q, wave_start_d;
    logic               key_armed_q, key_armed_d;
    logic               frame_meta_q, frame_sync_q, frame_prev_q;

    logic               frame_tick;
    logic               start_ok;
    logic               wave_done;
    logic [PW-1:0]      kill_pop;
    logic [KW-1:0]      kill_sum;
    logic [SUM_W-1:0]   score_sum;
    logic [SCORE_W-1:0] score_sat;

`ifdef GAME_SEQUENCER_HISCORE_EN
    logic [SCORE_W-1:0] hi_score_q, hi_score_d;
    logic               enter_gameover;
`endif

    // Rising edge of the synchronised frame strobe.
    assign frame_tick = frame_sync_q & ~frame_prev_q;

    // Count the enemies destroyed this cycle.
    always_comb begin
        kill_pop = '0;
        for (int unsigned i = 0; i < N_ENEMY; i++) begin
            kill_pop = kill_pop + PW'(kill_pulse[i]);
        end
    end

    // Saturating score update and wave completion detection.
    always_comb begin
        score_sum = SUM_W'(score_q) + SUM_W'(kill_pop);
        if (score_sum > SUM_W'({SCORE_W{1'b1}})) begin
            score_sat = '1;
        end else begin
            score_sat = score_sum[SCORE_W-1:0];
        end
        kill_sum  = kill_cnt_q + KW'(kill_pop);
        wave_done = (kill_sum >= KW'(N_ENEMY));
    end

    // Next-state and datapath logic for the game flow.
    always_comb begin
        state_d      = state_q;
        score_d      = score_q;
        lives_d      = lives_q;
        wave_num_d   = wave_num_q;
        kill_cnt_d   = kill_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        won_d        = won_q;
        wave_start_d = 1'b0;
        key_armed_d  = key_armed_q;

        start_ok = key_armed_q && (keycode == KEY_START) &&
                   ((state_q == S_ATTRACT) || (state_q == S_GAMEOVER));

        // Arming requires a key release, so a held start key cannot retrigger.
        if (start_ok) begin
            key_armed_d = 1'b0;
        end else if (keycode == 8'h00) begin
            key_armed_d = 1'b1;
        end

        case (state_q)
            S_ATTRACT, S_GAMEOVER: begin
                if (start_ok) begin
                    state_d      = S_PLAY;
                    score_d      = '0;
                    lives_d      = 3'(LIVES);
                    wave_num_d   = 4'd1;
                    kill_cnt_d   = '0;
                    frame_cnt_d  = '0;
                    won_d        = 1'b0;
                    wave_start_d = 1'b1;
                end
            end
            S_PLAY: begin
                score_d    = score_sat;
                kill_cnt_d = kill_sum;
                // Wave completion takes priority; a coincident hit is dropped.
                if (wave_done) begin
                    frame_cnt_d = '0;
                    if (wave_num_q < 4'(N_WAVES)) begin
                        state_d = S_WAVE_CLEAR;
                    end else begin
                        state_d = S_GAMEOVER;
                        won_d   = 1'b1;
                    end
                end else if (player_hit) begin
                    lives_d     = lives_q - 3'd1;
                    frame_cnt_d = '0;
                    if (lives_q == 3'd1) begin
                        state_d = S_GAMEOVER;
                    end else begin
                        state_d = S_RESPAWN;
                    end
                end
            end
            S_RESPAWN: begin
                if (frame_tick) begin
                    if (frame_cnt_q == FW'(RESPAWN_FRAMES - 1)) begin
                        state_d     = S_PLAY;
                        frame_cnt_d = '0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end
            S_WAVE_CLEAR: begin
                if (frame_tick) begin
                    if (frame_cnt_q == FW'(CLEAR_FRAMES - 1)) begin
                        state_d      = S_PLAY;
                        frame_cnt_d  = '0;
                        wave_num_d   = wave_num_q + 4'd1;
                        kill_cnt_d   = '0;
                        wave_start_d = 1'b1;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_ATTRACT;
            end
        endcase
    end

`ifdef GAME_SEQUENCER_HISCORE_EN
    // Capture a new best score on the transition into game over.
    always_comb begin
        enter_gameover = (state_d == S_GAMEOVER) && (state_q != S_GAMEOVER);
        hi_score_d     = hi_score_q;
        if (enter_gameover && (score_d > hi_score_q)) begin
            hi_score_d = score_d;
        end
    end
`endif

    // State, datapath and synchroniser registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= S_ATTRACT;
            score_q      <= '0;
            lives_q      <= '0;
            wave_num_q   <= '0;
            kill_cnt_q   <= '0;
            frame_cnt_q  <= '0;
            won_q        <= 1'b0;
            wave_start_q <= 1'b0;
            key_armed_q  <= 1'b0;
            frame_meta_q <= 1'b0;
            frame_sync_q <= 1'b0;
            frame_prev_q <= 1'b0;
`ifdef GAME_SEQUENCER_HISCORE_EN
            hi_score_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            lives_q      <= lives_d;
            wave_num_q   <= wave_num_d;
            kill_cnt_q   <= kill_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            won_q        <= won_d;
            wave_start_q <= wave_start_d;
            key_armed_q  <= key_armed_d;
            frame_meta_q <= frame_clk;
            frame_sync_q <= frame_meta_q;
            frame_prev_q <= frame_sync_q;
`ifdef GAME_SEQUENCER_HISCORE_EN
            hi_score_q   <= hi_score_d;
`endif
        end
    end

    assign start      = (state_q == S_ATTRACT);
    assign play       = (state_q == S_PLAY);
    assign respawn    = (state_q == S_RESPAWN);
    assign wave_clear = (state_q == S_WAVE_CLEAR);
    assign gameover   = (state_q == S_GAMEOVER);
    assign wave_start = wave_start_q;
    assign won        = won_q;
    assign lives      = lives_q;
    assign wave_num   = wave_num_q;
    assign score      = score_q;
`ifdef GAME_SEQUENCER_HISCORE_EN
    assign hi_score   = hi_score_q;
`endif

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed scenarios followed by randomized play, all
// checked every cycle against a behavioural game model. Two DUTs share the
// stimulus: default parameters and a 4-bit score to exercise saturation.
`timescale 1ns/1ps
module tb_game_sequencer;

    localparam int N_ENEMY = 18;
    localparam int LIVES   = 3;
    localparam int N_WAVES = 4;
    localparam int CF      = 120;
    localparam int RF      = 60;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic               rst;
    logic               fclk;
    logic [7:0]         key;
    logic [N_ENEMY-1:0] kills;
    logic               hit;

    logic       st0, pl0, rs0, wc0, go0, ws0, won0;
    logic [2:0] lv0;
    logic [3:0] wn0;
    logic [7:0] sc0;
    logic       st1, pl1, rs1, wc1, go1, ws1, won1;
    logic [2:0] lv1;
    logic [3:0] wn1;
    logic [3:0] sc1;
`ifdef GAME_SEQUENCER_HISCORE_EN
    logic [7:0] hi0;
    logic [3:0] hi1;
`endif

    game_sequencer #(
        .N_ENEMY(N_ENEMY), .LIVES(LIVES), .N_WAVES(N_WAVES), .SCORE_W(8),
        .KEY_START(8'h28), .CLEAR_FRAMES(CF), .RESPAWN_FRAMES(RF)
    ) u0 (
        .Clk(clk), .Reset(rst), .frame_clk(fclk), .keycode(key),
        .kill_pulse(kills), .player_hit(hit),
        .start(st0), .play(pl0), .respawn(rs0), .wave_clear(wc0), .gameover(go0),
        .wave_start(ws0), .won(won0), .lives(lv0), .wave_num(wn0), .score(sc0)
`ifdef GAME_SEQUENCER_HISCORE_EN
        , .hi_score(hi0)
`endif
    );

    game_sequencer #(
        .N_ENEMY(N_ENEMY), .LIVES(LIVES), .N_WAVES(N_WAVES), .SCORE_W(4),
        .KEY_START(8'h28), .CLEAR_FRAMES(CF), .RESPAWN_FRAMES(RF)
    ) u1 (
        .Clk(clk), .Reset(rst), .frame_clk(fclk), .keycode(key),
        .kill_pulse(kills), .player_hit(hit),
        .start(st1), .play(pl1), .respawn(rs1), .wave_clear(wc1), .gameover(go1),
        .wave_start(ws1), .won(won1), .lives(lv1), .wave_num(wn1), .score(sc1)
`ifdef GAME_SEQUENCER_HISCORE_EN
        , .hi_score(hi1)
`endif
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {M_ATTRACT = 0, M_PLAY = 1, M_RESPAWN = 2, M_CLEAR = 3, M_OVER = 4} mstate_t;
    mstate_t m_st[2];
    int      m_score[2], m_lives[2], m_wave[2], m_kc[2], m_fc[2], m_hi[2];
    bit      m_won[2], m_ws[2], m_armed[2];
    int      m_max[2] = '{255, 15};
    bit      fhist[3] = '{0, 0, 0};  // frame_clk sampled at the last three edges, newest first

    function automatic void model_step(input int i, input bit tick, input int k);
        bit accept;
        if (rst) begin
            m_st[i] = M_ATTRACT; m_score[i] = 0; m_lives[i] = 0; m_wave[i] = 0;
            m_kc[i] = 0; m_fc[i] = 0; m_hi[i] = 0;
            m_won[i] = 0; m_ws[i] = 0; m_armed[i] = 0;
            return;
        end
        accept = m_armed[i] && key == 8'h28 && (m_st[i] == M_ATTRACT || m_st[i] == M_OVER);
        if (accept) m_armed[i] = 0;
        else if (key == 8'h00) m_armed[i] = 1;
        m_ws[i] = 0;
        case (m_st[i])
            M_ATTRACT, M_OVER: begin
                if (accept) begin
                    m_st[i] = M_PLAY; m_score[i] = 0; m_lives[i] = LIVES; m_wave[i] = 1;
                    m_kc[i] = 0; m_fc[i] = 0; m_won[i] = 0; m_ws[i] = 1;
                end
            end
            M_PLAY: begin
                m_score[i] = (m_score[i] + k > m_max[i]) ? m_max[i] : m_score[i] + k;
                m_kc[i] += k;
                if (m_kc[i] >= N_ENEMY) begin
                    m_fc[i] = 0;
                    if (m_wave[i] < N_WAVES) m_st[i] = M_CLEAR;
                    else begin
                        m_st[i] = M_OVER; m_won[i] = 1;
                        if (m_score[i] > m_hi[i]) m_hi[i] = m_score[i];
                    end
                end else if (hit) begin
                    m_lives[i]--; m_fc[i] = 0;
                    if (m_lives[i] == 0) begin
                        m_st[i] = M_OVER;
                        if (m_score[i] > m_hi[i]) m_hi[i] = m_score[i];
                    end else m_st[i] = M_RESPAWN;
                end
            end
            M_RESPAWN: begin
                if (tick) begin
                    m_fc[i]++;
                    if (m_fc[i] == RF) begin m_st[i] = M_PLAY; m_fc[i] = 0; end
                end
            end
            M_CLEAR: begin
                if (tick) begin
                    m_fc[i]++;
                    if (m_fc[i] == CF) begin
                        m_st[i] = M_PLAY; m_fc[i] = 0; m_wave[i]++; m_kc[i] = 0; m_ws[i] = 1;
                    end
                end
            end
            default: m_st[i] = M_ATTRACT;
        endcase
    endfunction

    // Advance the model on every clock edge from the applied inputs.
    always @(posedge clk) begin
        bit tick;
        int k;
        tick = fhist[1] && !fhist[2];
        k = $countones(kills);
        for (int i = 0; i < 2; i++) model_step(i, tick, k);
        if (rst) fhist = '{0, 0, 0};
        else begin
            fhist[2] = fhist[1]; fhist[1] = fhist[0]; fhist[0] = fclk;
        end
    end

    task automatic cmp(input int i, input logic [4:0] fl, input logic ws, input logic wn_,
                       input logic [2:0] lv, input logic [3:0] wv, input int sc);
        logic [4:0] exp_fl;
        exp_fl = 5'b10000 >> m_st[i];
        check($sformatf("flags%0d", i), int'(fl), int'(exp_fl));
        check($sformatf("wave_start%0d", i), int'(ws), int'(m_ws[i]));
        check($sformatf("won%0d", i), int'(wn_), int'(m_won[i]));
        check($sformatf("lives%0d", i), int'(lv), m_lives[i]);
        check($sformatf("wave_num%0d", i), int'(wv), m_wave[i]);
        check($sformatf("score%0d", i), sc, m_score[i]);
    endtask

    // Compare both DUTs against the model every cycle, away from the clock edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            cmp(0, {st0, pl0, rs0, wc0, go0}, ws0, won0, lv0, wn0, int'(sc0));
            cmp(1, {st1, pl1, rs1, wc1, go1}, ws1, won1, lv1, wn1, int'(sc1));
`ifdef GAME_SEQUENCER_HISCORE_EN
            check("hi_score0", int'(hi0), m_hi[0]);
            check("hi_score1", int'(hi1), m_hi[1]);
`endif
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        fclk = 1'b0;
        forever begin
            @(negedge clk);
            if ($urandom_range(2) == 0) fclk = ~fclk;
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic pulse(input logic [N_ENEMY-1:0] mask, input logic h);
        kills = mask; hit = h;
        cyc();
        kills = '0; hit = 1'b0;
    endtask

    task automatic wait_play(input string tag);
        int n;
        n = 0;
        while (!pl0 && n < 5000) begin
            cyc();
            n++;
        end
        check(tag, int'(pl0), 1);
    endtask

    initial begin
        int r;
        rst = 1'b1; key = 8'h00; kills = '0; hit = 1'b0;
        cyc(); cyc();
        cmp_en = 1'b1;
        check("rst_start", int'(st0), 1);
        check("rst_lives", int'(lv0), 0);
        check("rst_wave", int'(wn0), 0);
        check("rst_score", int'(sc0), 0);

        // Arm, then press start.
        rst = 1'b0; key = 8'h00; cyc();
        key = 8'h28; cyc();
        check("start_play", int'(pl0), 1);
        check("start_lives", int'(lv0), 3);
        check("start_wave", int'(wn0), 1);
        check("start_score", int'(sc0), 0);
        check("start_pulse", int'(ws0), 1);
        cyc();
        check("start_pulse_single", int'(ws0), 0);

        // 18 kills: three in one cycle then fifteen singles.
        pulse(18'b111, 1'b0);
        for (int j = 0; j < 15; j++) pulse(18'(1) << (j + 3), 1'b0);
        check("wave1_clear", int'(wc0), 1);
        check("wave1_score", int'(sc0), 18);
        check("sat_score", int'(sc1), 15);
        wait_play("wave2_play");
        check("wave2_num", int'(wn0), 2);
        check("wave2_pulse", int'(ws0), 1);

        // Three hits with respawns in between.
        pulse('0, 1'b1);
        check("hit1_respawn", int'(rs0), 1);
        check("hit1_lives", int'(lv0), 2);
        wait_play("respawn1_play");
        pulse('0, 1'b1);
        check("hit2_lives", int'(lv0), 1);
        wait_play("respawn2_play");
        pulse('0, 1'b1);
        check("hit3_over", int'(go0), 1);
        check("hit3_won", int'(won0), 0);
        check("hit3_lives", int'(lv0), 0);

        // Start key still held: no restart.
        repeat (40) cyc();
        check("held_key_over", int'(go0), 1);
        check("over_hold_score", int'(sc0), 18);
        check("over_hold_wave", int'(wn0), 2);
`ifdef GAME_SEQUENCER_HISCORE_EN
        check("hi_after_over", int'(hi1), 15);
`endif
        key = 8'h00; cyc();
        check("release_over", int'(go0), 1);
        key = 8'h28; cyc();
        check("restart_play", int'(pl0), 1);
        check("restart_lives", int'(lv0), 3);
        check("restart_score", int'(sc0), 0);
`ifdef GAME_SEQUENCER_HISCORE_EN
        check("hi_after_restart", int'(hi1), 15);
`endif

        // Clear waves 1..3, then final kill of wave 4 together with a hit.
        for (int w = 1; w <= 3; w++) begin
            for (int j = 0; j < 18; j++) pulse(18'(1) << j, 1'b0);
            check($sformatf("w%0d_clear", w), int'(wc0), 1);
            wait_play($sformatf("w%0d_next", w));
        end
        check("wave4_num", int'(wn0), 4);
        for (int j = 0; j < 17; j++) pulse(18'(1) << j, 1'b0);
        pulse(18'(1) << 17, 1'b1);
        check("win_over", int'(go0), 1);
        check("win_won", int'(won0), 1);
        check("win_lives", int'(lv0), 3);

        // Randomized play.
        repeat (20000) begin
            rst = ($urandom_range(2999) == 0);
            r = $urandom_range(9);
            key = (r < 4) ? 8'h00 : (r < 8) ? 8'h28 : 8'($urandom_range(255));
            kills = '0;
            if ($urandom_range(3) == 0) begin
                r = $urandom_range(9);
                if (r == 0) kills = '1;
                else if (r < 3) kills = 18'($urandom);
                else kills[$urandom_range(17)] = 1'b1;
            end
            hit = ($urandom_range(39) == 0);
            cyc();
        end
        rst = 1'b0; kills = '0; hit = 1'b0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
